// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit and memory.
// The master drives the request side; the slave answers with ready/rdata.
interface lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one access from ex, runs a ready handshake on the
// data bus with a bounded wait, and writes extended load data back to regs.
// Misaligned or illegal accesses and bus timeouts raise a one-cycle err_o.
module lsu #(
   parameter int TIMEOUT   = 16,
   parameter int TIMEOUT_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid_i,
   input  logic         req_we_i,
   input  logic [2:0]   req_func3_i,
   input  logic [31:0]  req_addr_i,
   input  logic [31:0]  req_wdata_i,
   input  logic [4:0]   req_rd_addr_i,
   lsu_if.master        mem,
   output logic [4:0]   rd_addr_o,
   output logic [31:0]  rd_data_o,
   output logic         rd_wen_o,
   output logic         hold_flag_o,
   output logic         err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2
   } state_e;

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);
   localparam logic [TIMEOUT_W-1:0] CNT_ONE     = TIMEOUT_W'(1);

   // Access is legal and naturally aligned for its size; illegal func3 counts as misaligned.
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = (off[0] == 1'b0);
         3'b010:         ok = (off == 2'b00);
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte strobes for a store of the given size at the given byte offset.
   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Store data replicated across all lanes so the strobes alone pick the bytes.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{w[7:0]}};
         2'b01:   d = {2{w[15:0]}};
         default: d = w;
      endcase
      return d;
   endfunction

   // Select the addressed byte/half of the read word and sign- or zero-extend it.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'h000000, b};
         3'b101:  r = {16'h0000, h};
         default: r = w;
      endcase
      return r;
   endfunction

   state_e               state_q,     state_d;
   logic [TIMEOUT_W-1:0] cnt_q,       cnt_d;
   logic                 we_q,        we_d;
   logic [2:0]           func3_q,     func3_d;
   logic [1:0]           off_q,       off_d;
   logic [4:0]           rd_addr_q,   rd_addr_d;
   logic [31:0]          rd_data_q,   rd_data_d;
   logic                 rd_wen_q,    rd_wen_d;
   logic                 err_q,       err_d;
   logic                 mem_req_q,   mem_req_d;
   logic                 mem_we_q,    mem_we_d;
   logic [31:0]          mem_addr_q,  mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic [3:0]           mem_wstrb_q, mem_wstrb_d;

   logic                 aligned_s;
   logic [TIMEOUT_W-1:0] cnt_inc_s;

   assign aligned_s = is_aligned(req_func3_i, req_addr_i[1:0]);
   assign cnt_inc_s = cnt_q + CNT_ONE;

   // Stall request: an access about to be accepted, or one waiting on the bus.
   always_comb begin
      hold_flag_o = ((state_q == S_IDLE) && req_valid_i && aligned_s) || (state_q == S_REQ);
   end

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      func3_d     = func3_q;
      off_d       = off_q;
      rd_addr_d   = rd_addr_q;
      rd_data_d   = rd_data_q;
      rd_wen_d    = 1'b0;
      err_d       = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               if (aligned_s) begin
                  we_d        = req_we_i;
                  func3_d     = req_func3_i;
                  off_d       = req_addr_i[1:0];
                  rd_addr_d   = req_rd_addr_i;
                  cnt_d       = {TIMEOUT_W{1'b0}};
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we_i;
                  mem_addr_d  = {req_addr_i[31:2], 2'b00};
                  mem_wdata_d = req_we_i ? store_data(req_func3_i, req_wdata_i) : 32'h00000000;
                  mem_wstrb_d = req_we_i ? store_strb(req_func3_i, req_addr_i[1:0]) : 4'b0000;
                  state_d     = S_REQ;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_REQ: begin
            cnt_d = cnt_inc_s;
            // Ready is checked before the timeout so a completion on the last
            // allowed cycle still succeeds.
            if (mem.mem_ready) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               if (we_q) begin
                  state_d = S_IDLE;
               end else begin
                  rd_data_d = load_ext(func3_q, off_q, mem.mem_rdata);
                  rd_wen_d  = (rd_addr_q != 5'd0);
                  state_d   = S_WB;
               end
            end else if (cnt_inc_s == TIMEOUT_CNT) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               err_d       = 1'b1;
               state_d     = S_IDLE;
            end else begin
               state_d = S_REQ;
            end
         end

         S_WB: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d     = S_IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
         end
      endcase
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= {TIMEOUT_W{1'b0}};
         we_q        <= 1'b0;
         func3_q     <= 3'b000;
         off_q       <= 2'b00;
         rd_addr_q   <= 5'd0;
         rd_data_q   <= 32'h00000000;
         rd_wen_q    <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h00000000;
         mem_wdata_q <= 32'h00000000;
         mem_wstrb_q <= 4'b0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         func3_q     <= func3_d;
         off_q       <= off_d;
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         rd_wen_q    <= rd_wen_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_wstrb = mem_wstrb_q;
   assign rd_addr_o     = rd_addr_q;
   assign rd_data_o     = rd_data_q;
   assign rd_wen_o      = rd_wen_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus randomized accesses checked
// against a behavioural model of the access rules.
module tb_lsu;
   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_func3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd_addr;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_wen;
   logic        hold_flag;
   logic        err;

   lsu_if mif ();

   lsu #(.TIMEOUT(TO), .TIMEOUT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid),
      .req_we_i      (req_we),
      .req_func3_i   (req_func3),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .req_rd_addr_i (req_rd_addr),
      .mem           (mif),
      .rd_addr_o     (rd_addr),
      .rd_data_o     (rd_data),
      .rd_wen_o      (rd_wen),
      .hold_flag_o   (hold_flag),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations gathered over one access window
   int          obs_hold, obs_req, obs_err, obs_wen, obs_err_cyc, obs_wen_cyc;
   logic [31:0] obs_rd_data, obs_addr, obs_wdata;
   logic [4:0]  obs_rd_addr;
   logic [3:0]  obs_wstrb;
   logic        obs_we, obs_unstable;

   // Present one request for one cycle, act as memory (ready on the delay-th
   // request cycle, 0 = never) and record what the DUT does over 22 cycles.
   // Entered and left just after a rising edge.
   task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd,
                             input int delay, input logic [31:0] rdata);
      int k;
      obs_hold = 0; obs_req = 0; obs_err = 0; obs_wen = 0;
      obs_err_cyc = -1; obs_wen_cyc = -1; obs_unstable = 1'b0;
      obs_rd_data = 32'h0; obs_rd_addr = 5'd0;
      obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0; obs_we = 1'b0;
      req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr;
      req_wdata = wdata; req_rd_addr = rd;
      k = 0;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (hold_flag) obs_hold++;
         if (err) begin obs_err++; obs_err_cyc = c; end
         if (rd_wen) begin
            obs_wen++; obs_wen_cyc = c; obs_rd_data = rd_data; obs_rd_addr = rd_addr;
         end
         mif.mem_ready = 1'b0;
         mif.mem_rdata = $urandom;
         if (mif.mem_req) begin
            k++; obs_req++;
            if (k == 1) begin
               obs_addr = mif.mem_addr; obs_wdata = mif.mem_wdata;
               obs_wstrb = mif.mem_wstrb; obs_we = mif.mem_we;
            end else if (mif.mem_addr !== obs_addr || mif.mem_wdata !== obs_wdata ||
                         mif.mem_wstrb !== obs_wstrb || mif.mem_we !== obs_we) begin
               obs_unstable = 1'b1;
            end
            if (k == delay) begin
               mif.mem_ready = 1'b1;
               mif.mem_rdata = rdata;
            end
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
      mif.mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      for (int p = 0; p < 2; p++) begin
         n_checks++;
         if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb,
              rd_addr, rd_data, rd_wen, err, hold_flag} !== 80'h0)
            $display("FAIL reset_outputs phase=%0d got req=%b we=%b addr=%h wdata=%h strb=%b rd=%0d data=%h wen=%b err=%b hold=%b want all 0",
                     p, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb,
                     rd_addr, rd_data, rd_wen, err, hold_flag);
         else n_pass++;
         if (p == 0) begin
            rst = 1'b0;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_spec_loads();
      run_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF);
      n_checks++; if (obs_hold !== 4) $display("FAIL lw_hold got %0d want 4", obs_hold); else n_pass++;
      n_checks++; if (obs_wen !== 1) $display("FAIL lw_wen_count got %0d want 1", obs_wen); else n_pass++;
      n_checks++; if (obs_rd_data !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", obs_rd_data); else n_pass++;
      n_checks++; if (obs_rd_addr !== 5'd5) $display("FAIL lw_rd_addr got %0d want 5", obs_rd_addr); else n_pass++;
      n_checks++; if (obs_wen_cyc !== 4) $display("FAIL lw_wb_cycle got %0d want 4", obs_wen_cyc); else n_pass++;
      n_checks++; if (obs_addr !== 32'h100 || obs_wstrb !== 4'b0000 || obs_we !== 1'b0)
         $display("FAIL lw_bus got addr=%h strb=%b we=%b want 100/0000/0", obs_addr, obs_wstrb, obs_we); else n_pass++;

      run_access(1'b0, 3'b000, 32'h103, 32'h0, 5'd9, 1, 32'h80FFFFFF);
      n_checks++; if (obs_rd_data !== 32'hFFFFFF80 || obs_wen !== 1) $display("FAIL lb_data got %h wen=%0d want ffffff80", obs_rd_data, obs_wen); else n_pass++;
      n_checks++; if (obs_wen_cyc !== 2) $display("FAIL load_latency got %0d want 2", obs_wen_cyc); else n_pass++;
      run_access(1'b0, 3'b100, 32'h103, 32'h0, 5'd9, 1, 32'h80FFFFFF);
      n_checks++; if (obs_rd_data !== 32'h00000080) $display("FAIL lbu_data got %h want 00000080", obs_rd_data); else n_pass++;
      run_access(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 2, 32'h80FFFFFF);
      n_checks++; if (obs_rd_data !== 32'h000080FF) $display("FAIL lhu_data got %h want 000080ff", obs_rd_data); else n_pass++;
      run_access(1'b0, 3'b010, 32'h110, 32'h0, 5'd0, 1, 32'h12345678);
      n_checks++; if (obs_wen !== 0 || obs_req !== 1) $display("FAIL rd0_no_wen got wen=%0d req=%0d want 0/1", obs_wen, obs_req); else n_pass++;
   endtask

   task automatic test_spec_stores();
      run_access(1'b1, 3'b000, 32'h101, 32'h000000AB, 5'd3, 1, 32'h0);
      n_checks++; if (obs_wstrb !== 4'b0010 || obs_wdata !== 32'hABABABAB || obs_we !== 1'b1)
         $display("FAIL sb_bus got strb=%b wdata=%h we=%b want 0010/abababab/1", obs_wstrb, obs_wdata, obs_we); else n_pass++;
      n_checks++; if (obs_wen !== 0 || obs_hold !== 2 || obs_addr !== 32'h100)
         $display("FAIL sb_done got wen=%0d hold=%0d addr=%h want 0/2/100", obs_wen, obs_hold, obs_addr); else n_pass++;
      run_access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5'd3, 2, 32'h0);
      n_checks++; if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hBEEFBEEF)
         $display("FAIL sh_bus got strb=%b wdata=%h want 1100/beefbeef", obs_wstrb, obs_wdata); else n_pass++;
   endtask

   task automatic test_misaligned();
      run_access(1'b0, 3'b010, 32'h102, 32'h0, 5'd4, 1, 32'h11111111);
      n_checks++; if (obs_err !== 1 || obs_err_cyc !== 1) $display("FAIL misalign_err got n=%0d cyc=%0d want 1/1", obs_err, obs_err_cyc); else n_pass++;
      n_checks++; if (obs_req !== 0 || obs_hold !== 0 || obs_wen !== 0)
         $display("FAIL misalign_quiet got req=%0d hold=%0d wen=%0d want 0/0/0", obs_req, obs_hold, obs_wen); else n_pass++;
      run_access(1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 1, 32'h11111111);
      n_checks++; if (obs_err !== 1 || obs_req !== 0) $display("FAIL illegal_f3 got err=%0d req=%0d want 1/0", obs_err, obs_req); else n_pass++;
   endtask

   task automatic test_timeout();
      run_access(1'b0, 3'b010, 32'h300, 32'h0, 5'd6, 0, 32'h0);
      n_checks++; if (obs_req !== TO) $display("FAIL timeout_req_cycles got %0d want %0d", obs_req, TO); else n_pass++;
      n_checks++; if (obs_err !== 1 || obs_err_cyc !== TO + 1) $display("FAIL timeout_err got n=%0d cyc=%0d want 1/%0d", obs_err, obs_err_cyc, TO + 1); else n_pass++;
      n_checks++; if (obs_wen !== 0 || obs_hold !== TO + 1) $display("FAIL timeout_quiet got wen=%0d hold=%0d want 0/%0d", obs_wen, obs_hold, TO + 1); else n_pass++;
      run_access(1'b0, 3'b010, 32'h304, 32'h0, 5'd6, 1, 32'hCAFEF00D);
      n_checks++; if (obs_rd_data !== 32'hCAFEF00D || obs_wen_cyc !== 2) $display("FAIL after_timeout got data=%h cyc=%0d want cafef00d/2", obs_rd_data, obs_wen_cyc); else n_pass++;
      run_access(1'b0, 3'b010, 32'h308, 32'h0, 5'd6, TO, 32'h0BADCAFE);
      n_checks++; if (obs_err !== 0 || obs_wen !== 1 || obs_rd_data !== 32'h0BADCAFE)
         $display("FAIL ready_at_timeout got err=%0d wen=%0d data=%h want 0/1/0badcafe", obs_err, obs_wen, obs_rd_data); else n_pass++;
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h400;
      req_wdata = 32'h11223344; req_rd_addr = 5'd1;
      @(negedge clk);
      @(posedge clk); #1;
      req_addr = 32'h502; req_func3 = 3'b001; req_wdata = 32'h00005566;
      @(negedge clk);
      n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h400 || mif.mem_wstrb !== 4'b1111)
         $display("FAIL b2b_first got req=%b addr=%h strb=%b want 1/400/1111", mif.mem_req, mif.mem_addr, mif.mem_wstrb); else n_pass++;
      mif.mem_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      mif.mem_ready = 1'b0;
      n_checks++; if (mif.mem_req !== 1'b0 || hold_flag !== 1'b1)
         $display("FAIL b2b_gap got req=%b hold=%b want 0/1", mif.mem_req, hold_flag); else n_pass++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h500 || mif.mem_wstrb !== 4'b1100 || mif.mem_wdata !== 32'h55665566)
         $display("FAIL b2b_second got req=%b addr=%h strb=%b wdata=%h want 1/500/1100/55665566",
                  mif.mem_req, mif.mem_addr, mif.mem_wstrb, mif.mem_wdata); else n_pass++;
      mif.mem_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      mif.mem_ready = 1'b0;
      n_checks++; if (mif.mem_req !== 1'b0 || hold_flag !== 1'b0)
         $display("FAIL b2b_end got req=%b hold=%b want 0/0", mif.mem_req, hold_flag); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access();
      req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h200; req_rd_addr = 5'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (mif.mem_req !== 1'b1) $display("FAIL mid_in_req got %b want 1", mif.mem_req); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb,
           rd_addr, rd_data, rd_wen, err, hold_flag} !== 80'h0)
         $display("FAIL mid_reset got req=%b addr=%h rd=%0d data=%h wen=%b err=%b hold=%b want all 0",
                  mif.mem_req, mif.mem_addr, rd_addr, rd_data, rd_wen, err, hold_flag);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_access(1'b0, 3'b010, 32'h204, 32'h0, 5'd7, 2, 32'h12345678);
      n_checks++; if (obs_wen !== 1 || obs_rd_data !== 32'h12345678 || obs_err !== 0)
         $display("FAIL post_reset_lw got wen=%0d data=%h err=%0d want 1/12345678/0", obs_wen, obs_rd_data, obs_err); else n_pass++;
   endtask

   task automatic test_random();
      logic [2:0]  load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  bad_f3  [3] = '{3'b011, 3'b110, 3'b111};
      logic        we, legal, aligned, to;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata, v, ew;
      logic [4:0]  rd;
      logic [3:0]  es;
      int          size, idx, delay, n, r, exp_wen;
      for (int it = 0; it < 40; it++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 6) == 0) f3 = bad_f3[$urandom_range(0, 2)];
         else if (we) f3 = 3'($urandom_range(0, 2));
         else f3 = load_f3[$urandom_range(0, 4)];
         idx   = $urandom_range(0, 3);
         addr  = 32'h1000 + (($urandom & 32'hFF) << 2) + 32'(idx);
         wdata = $urandom; rdata = $urandom;
         rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r     = $urandom_range(0, 9);
         delay = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 4);

         // Reference model
         size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         legal   = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
         aligned = legal && ((idx % size) == 0);
         to      = (delay == 0) || (delay > TO);
         n       = to ? TO : delay;
         v = rdata >> (8 * idx);
         if (size < 4) begin
            v = v & ((32'h1 << (8 * size)) - 32'h1);
            if (!f3[2] && v[8 * size - 1]) v = v - (32'h1 << (8 * size));
         end
         for (int b = 0; b < 4; b++) ew[8 * b +: 8] = wdata[8 * (b % size) +: 8];
         es = 4'(((1 << size) - 1) << idx);
         exp_wen = (aligned && !we && !to && rd != 5'd0) ? 1 : 0;

         run_access(we, f3, addr, wdata, rd, delay, rdata);

         if (!aligned) begin
            n_checks++; if (obs_err !== 1 || obs_req !== 0 || obs_hold !== 0 || obs_wen !== 0)
               $display("FAIL rnd_misalign it=%0d f3=%b addr=%h got err=%0d req=%0d hold=%0d wen=%0d want 1/0/0/0",
                        it, f3, addr, obs_err, obs_req, obs_hold, obs_wen); else n_pass++;
         end else begin
            n_checks++; if (obs_req !== n || obs_hold !== n + 1 || obs_err !== (to ? 1 : 0) || obs_wen !== exp_wen)
               $display("FAIL rnd_timing it=%0d got req=%0d hold=%0d err=%0d wen=%0d want %0d/%0d/%0d/%0d",
                        it, obs_req, obs_hold, obs_err, obs_wen, n, n + 1, to ? 1 : 0, exp_wen); else n_pass++;
            n_checks++; if (obs_addr !== (addr & 32'hFFFFFFFC) || obs_we !== we || obs_unstable !== 1'b0 ||
                            obs_wstrb !== (we ? es : 4'b0000))
               $display("FAIL rnd_bus it=%0d got addr=%h we=%b strb=%b unstable=%b want %h/%b/%b/0",
                        it, obs_addr, obs_we, obs_wstrb, obs_unstable, addr & 32'hFFFFFFFC, we, we ? es : 4'b0000); else n_pass++;
            if (we) begin
               n_checks++; if (obs_wdata !== ew)
                  $display("FAIL rnd_wdata it=%0d f3=%b got %h want %h", it, f3, obs_wdata, ew); else n_pass++;
            end
            if (exp_wen == 1) begin
               n_checks++; if (obs_rd_data !== v || obs_rd_addr !== rd || obs_wen_cyc !== n + 1)
                  $display("FAIL rnd_load it=%0d f3=%b addr=%h got data=%h rd=%0d cyc=%0d want %h/%0d/%0d",
                           it, f3, addr, obs_rd_data, obs_rd_addr, obs_wen_cyc, v, rd, n + 1); else n_pass++;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000; req_addr = 32'h0;
      req_wdata = 32'h0; req_rd_addr = 5'd0;
      mif.mem_ready = 1'b0; mif.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_spec_loads();
      test_spec_stores();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
